prefetch_engine: RTL and testbench
==================================

Name: prefetch_engine

Overview:
- Parametrised successor to the linear-address prefetch controller.
- Tracks the CS-relative linear fetch pointer and the bytes remaining to the segment limit.
- Issues fetch requests to the TLB over a valid/ready handshake. Length is clamped by burst size, segment limit, free prefetch-FIFO space and, optionally, 4 KB page boundary.
- Keeps one request outstanding, drops stale responses after a flush, and signals limit exhaustion exactly once per flush.

Parameters:
- MAX_LEN, 16: maximum bytes per request; power of two, 4..64.
- LEN_W, 7: width of length fields; must satisfy 2^(LEN_W-1) >= MAX_LEN.
- FREE_W, 6: width of fifo_free.
- SPLIT_PAGE, 1: when 1, no request crosses a 4 KB linear boundary.
- STARTUP_LINEAR, 32'hFFFF_FFF0: linear pointer after reset.
- STARTUP_LIMIT, 33'd16: remaining bytes after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pr_reset  in  1  flush; reload pointer and limit from CS/EIP
- prefetch_cpl  in  2  current privilege level
- prefetch_eip  in  32  EIP to restart at
- cs_cache  in  64  CS descriptor cache
- fifo_free  in  FREE_W  free bytes in the downstream prefetch FIFO
- req_valid  out  1  request valid
- req_ready  in  1  TLB accepts request
- req_address  out  32  linear address
- req_length  out  LEN_W  requested bytes, 1..MAX_LEN
- req_su  out  1  1 = user (cpl==3)
- rsp_valid  in  1  response for the outstanding request
- rsp_length  in  LEN_W  bytes actually delivered
- rsp_keep  out  1  combinational; 1 = deliver this response to the FIFO, 0 = discard
- limit_signal_do  out  1  one-cycle pulse: segment limit reached

Behaviour:
- Descriptor decode:
  - cs_base = {cs_cache[63:56], cs_cache[39:16]}.
  - cs_limit = G (bit 55) ? {cs_cache[51:48], cs_cache[15:0], 12'hFFF} : zero-extended {cs_cache[51:48], cs_cache[15:0]}.
- Registers:
  - linear: 32 bits, wraps modulo 2^32.
  - limit: 33 bits, so cs_limit=FFFF_FFFF with eip=0 yields 2^32, not 0.
  - sent_len: LEN_W bits.
  - discard: 1 bit.
  - signaled: 1 bit.
  - state: IDLE, ISSUE, WAIT.
- On pr_reset:
  - linear <= cs_base + eip.
  - limit <= (cs_limit >= eip) ? cs_limit - eip + 1 : 0.
  - signaled <= 0.
- Candidate length: len = min(MAX_LEN, limit, fifo_free, SPLIT_PAGE ? 4096 - linear[11:0] : MAX_LEN), evaluated combinationally each cycle.
- IDLE:
  - Go to ISSUE when limit != 0 and len != 0.
  - With limit == 0: stay in IDLE.
- ISSUE:
  - req_valid = 1; address, length and su are driven from current registers and held stable while req_valid && !req_ready.
  - len is latched into sent_len on the ISSUE entry cycle, so fifo_free changes cannot alter a pending request.
  - On req_ready, go to WAIT.
- WAIT:
  - On rsp_valid, d = min(rsp_length, sent_len).
  - If !discard: linear += d, limit -= d.
  - discard <= 0; go to IDLE. Next issue is no earlier than the following cycle.
  - rsp_length = 0 is legal: no progress, return to IDLE.
  - rsp_keep = rsp_valid && state==WAIT && !discard.
- pr_reset by state:
  - In IDLE or ISSUE: abort the request (req_valid drops next cycle), reload, go to IDLE.
  - In WAIT: reload, set discard = 1, stay in WAIT.
  - Coincident with rsp_valid: the response is discarded and the reload wins.
  - Coincident with req_ready: treated as accepted, so go to WAIT with discard = 1.
- limit_signal_do = (limit == 0) && !signaled && (state == IDLE) && !pr_reset. It sets signaled, so it pulses once per flush.
- Reset values: all outputs 0 except req_su = (prefetch_cpl==3); state IDLE; linear = STARTUP_LINEAR; limit = STARTUP_LIMIT; discard = 0; signaled = 0.
- Reset mid-transaction: the outstanding response is not tracked; the environment must not deliver it.
- Latency: flush to first req_valid is 2 cycles, given sufficient fifo_free.

Decomposition:
- Shared package (existing defines file):
  - STARTUP_PREFETCH_LINEAR and STARTUP_PREFETCH_LIMIT.
  - DESC_BIT_G and descriptor field offsets.
  - State encodings PF_IDLE/PF_ISSUE/PF_WAIT.
- One natural sub-module: prefetch_len_clamp. It is the combinational min-of-four with page-distance calculation, unit-testable in isolation.

Test Plan:
- cs base 0x1000, limit 0xFFFF (G=0), eip 0x10, fifo_free 32, MAX_LEN 16, always ready, rsp_length = req_length -> requests at 0x1010, 0x1020, ... each 16 bytes; after 0xFFF0 bytes total, limit_signal_do pulses once.
- eip 0xFFFA, limit 0xFFFF -> single request of length 6, then limit_signal_do pulse; no further req_valid.
- G=1, limit field 0xFFFFF, base 0, eip 0 -> limit register = 2^32; req_length 16; limit_signal_do not asserted.
- linear 0x0000_0FF8, SPLIT_PAGE=1 -> req_length 8, then next request at 0x1000 with length 16.
- pr_reset while in WAIT, rsp arrives 3 cycles later with length 16 -> rsp_keep=0; linear equals the new cs_base+eip; next request issued from the new address.
- fifo_free=3, req_ready held low 4 cycles while fifo_free rises to 20 -> req_length stays 3 until accepted; rsp_length 10 returned for a request of length 3 -> advance by 3 only.

Source files
------------

// File: rtl/prefetch_engine_pkg.sv
// Shared definitions for the linear-address prefetch engine: startup values,
// CS descriptor field layout, FSM state encoding and descriptor decode helpers.
package prefetch_engine_pkg;

   localparam logic [31:0] STARTUP_PREFETCH_LINEAR = 32'hFFFF_FFF0;
   localparam logic [32:0] STARTUP_PREFETCH_LIMIT  = 33'd16;

   // Descriptor field offsets
   localparam int DESC_BIT_G         = 55;
   localparam int DESC_BASE_HI_MSB   = 63;
   localparam int DESC_BASE_HI_LSB   = 56;
   localparam int DESC_BASE_LO_MSB   = 39;
   localparam int DESC_BASE_LO_LSB   = 16;
   localparam int DESC_LIMIT_HI_MSB  = 51;
   localparam int DESC_LIMIT_HI_LSB  = 48;
   localparam int DESC_LIMIT_LO_MSB  = 15;
   localparam int DESC_LIMIT_LO_LSB  = 0;

   typedef enum logic [1:0] {
      PF_IDLE  = 2'd0,
      PF_ISSUE = 2'd1,
      PF_WAIT  = 2'd2
   } pf_state_t;

   // Segment base as assembled from the split descriptor fields
   function automatic logic [31:0] desc_base(input logic [63:0] desc);
      return {desc[DESC_BASE_HI_MSB:DESC_BASE_HI_LSB],
              desc[DESC_BASE_LO_MSB:DESC_BASE_LO_LSB]};
   endfunction

   // Byte-granular segment limit; G scales the 20-bit field to 4 KB units
   function automatic logic [31:0] desc_limit(input logic [63:0] desc);
      logic [19:0] field;
      field = {desc[DESC_LIMIT_HI_MSB:DESC_LIMIT_HI_LSB],
               desc[DESC_LIMIT_LO_MSB:DESC_LIMIT_LO_LSB]};
      if (desc[DESC_BIT_G]) begin
         return {field, 12'hFFF};
      end else begin
         return {12'h000, field};
      end
   endfunction

endpackage

// File: rtl/prefetch_len_clamp.sv
// Combinational request-length clamp: the smallest of the burst size, the
// bytes left to the segment limit, the free FIFO space and (optionally) the
// distance to the next 4 KB linear page boundary.
module prefetch_len_clamp #(
   parameter int MAX_LEN    = 16,
   parameter int LEN_W      = 7,
   parameter int FREE_W     = 6,
   parameter int SPLIT_PAGE = 1
) (
   input  logic [32:0]       limit,
   input  logic [FREE_W-1:0] fifo_free,
   input  logic [11:0]       page_offset,
   output logic [LEN_W-1:0]  len
);

   logic [32:0] page_dist_s;
   logic [32:0] free_s;
   logic [32:0] min_s;

   // Running minimum in a 33-bit domain so no operand is truncated early
   always_comb begin
      page_dist_s = 33'd4096 - {21'd0, page_offset};
      free_s      = {{(33-FREE_W){1'b0}}, fifo_free};
      min_s       = 33'(MAX_LEN);
      min_s       = (limit  < min_s) ? limit  : min_s;
      min_s       = (free_s < min_s) ? free_s : min_s;
      min_s       = ((SPLIT_PAGE != 0) && (page_dist_s < min_s)) ? page_dist_s : min_s;
      len         = LEN_W'(min_s);
   end

endmodule

// File: rtl/prefetch_engine.sv
// Linear-address prefetch engine: tracks the CS-relative fetch pointer and the
// bytes left to the segment limit, issues one clamped fetch request at a time
// to the TLB and drops responses that belong to a flushed stream.
module prefetch_engine
   import prefetch_engine_pkg::*;
#(
   parameter int          MAX_LEN        = 16,
   parameter int          LEN_W          = 7,
   parameter int          FREE_W         = 6,
   parameter int          SPLIT_PAGE     = 1,
   parameter logic [31:0] STARTUP_LINEAR = STARTUP_PREFETCH_LINEAR,
   parameter logic [32:0] STARTUP_LIMIT  = STARTUP_PREFETCH_LIMIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pr_reset,
   input  logic [1:0]        prefetch_cpl,
   input  logic [31:0]       prefetch_eip,
   input  logic [63:0]       cs_cache,
   input  logic [FREE_W-1:0] fifo_free,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [31:0]       req_address,
   output logic [LEN_W-1:0]  req_length,
   output logic              req_su,
   input  logic              rsp_valid,
   input  logic [LEN_W-1:0]  rsp_length,
   output logic              rsp_keep,
   output logic              limit_signal_do
);

   pf_state_t        state_r;
   pf_state_t        state_nxt_s;
   logic [31:0]      linear_r;
   logic [32:0]      limit_r;
   logic [LEN_W-1:0] sent_len_r;
   logic             discard_r;
   logic             signaled_r;

   logic [31:0]      cs_base_s;
   logic [31:0]      cs_limit_s;
   logic [31:0]      reload_linear_s;
   logic [32:0]      reload_limit_s;
   logic [LEN_W-1:0] len_s;
   logic [LEN_W-1:0] rsp_step_s;

   prefetch_len_clamp #(
      .MAX_LEN    (MAX_LEN),
      .LEN_W      (LEN_W),
      .FREE_W     (FREE_W),
      .SPLIT_PAGE (SPLIT_PAGE)
   ) u_len_clamp (
      .limit       (limit_r),
      .fifo_free   (fifo_free),
      .page_offset (linear_r[11:0]),
      .len         (len_s)
   );

   // Reload values from the CS cache/EIP and the progress made by a response
   always_comb begin
      cs_base_s       = desc_base(cs_cache);
      cs_limit_s      = desc_limit(cs_cache);
      reload_linear_s = cs_base_s + prefetch_eip;
      // Limit is inclusive, so limit=FFFF_FFFF with eip=0 leaves 2^32 bytes
      if (cs_limit_s >= prefetch_eip) begin
         reload_limit_s = {1'b0, cs_limit_s} - {1'b0, prefetch_eip} + 33'd1;
      end else begin
         reload_limit_s = 33'd0;
      end
      // A TLB reporting more than was asked for only advances by the request
      rsp_step_s = (rsp_length < sent_len_r) ? rsp_length : sent_len_r;
   end

   // Next-state decode; a flush in WAIT keeps waiting for the stale response
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         PF_IDLE: begin
            if (pr_reset) begin
               state_nxt_s = PF_IDLE;
            end else if ((limit_r != 33'd0) && (len_s != '0)) begin
               state_nxt_s = PF_ISSUE;
            end else begin
               state_nxt_s = PF_IDLE;
            end
         end
         PF_ISSUE: begin
            if (req_ready) begin
               state_nxt_s = PF_WAIT;
            end else if (pr_reset) begin
               state_nxt_s = PF_IDLE;
            end else begin
               state_nxt_s = PF_ISSUE;
            end
         end
         PF_WAIT: begin
            if (rsp_valid) begin
               state_nxt_s = PF_IDLE;
            end else begin
               state_nxt_s = PF_WAIT;
            end
         end
         default: begin
            state_nxt_s = PF_IDLE;
         end
      endcase
   end

   // Output decode; address/length read as zero whenever no request is offered
   always_comb begin
      req_valid       = (state_r == PF_ISSUE);
      req_address     = req_valid ? linear_r : 32'd0;
      req_length      = req_valid ? sent_len_r : '0;
      req_su          = (prefetch_cpl == 2'd3);
      // A response coinciding with a flush belongs to the old stream
      rsp_keep        = rsp_valid && (state_r == PF_WAIT) && !discard_r && !pr_reset;
      limit_signal_do = (limit_r == 33'd0) && !signaled_r && (state_r == PF_IDLE) && !pr_reset;
   end

   // State, pointer, limit, pending length and flush bookkeeping registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= PF_IDLE;
         linear_r   <= STARTUP_LINEAR;
         limit_r    <= STARTUP_LIMIT;
         sent_len_r <= '0;
         discard_r  <= 1'b0;
         signaled_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;

         // Freeze the length on ISSUE entry so later fifo_free moves are ignored
         if ((state_r == PF_IDLE) && (state_nxt_s == PF_ISSUE)) begin
            sent_len_r <= len_s;
         end

         if (pr_reset) begin
            linear_r <= reload_linear_s;
            limit_r  <= reload_limit_s;
         end else if ((state_r == PF_WAIT) && rsp_valid && !discard_r) begin
            linear_r <= linear_r + 32'(rsp_step_s);
            limit_r  <= limit_r - 33'(rsp_step_s);
         end

         // Mark the in-flight request stale when a flush overtakes it
         if ((state_r == PF_WAIT) && pr_reset && !rsp_valid) begin
            discard_r <= 1'b1;
         end else if ((state_r == PF_ISSUE) && pr_reset && req_ready) begin
            discard_r <= 1'b1;
         end else if ((state_r == PF_WAIT) && rsp_valid) begin
            discard_r <= 1'b0;
         end

         if (pr_reset) begin
            signaled_r <= 1'b0;
         end else if (limit_signal_do) begin
            signaled_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_prefetch_engine.sv
// Self-checking bench for prefetch_engine: directed scenarios plus randomized
// sessions, all compared against a transaction-level reference model.
module tb_prefetch_engine;

   localparam int MAX_LEN = 16;
   localparam int LEN_W   = 7;
   localparam int FREE_W  = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              pr_reset;
   logic [1:0]        prefetch_cpl;
   logic [31:0]       prefetch_eip;
   logic [63:0]       cs_cache;
   logic [FREE_W-1:0] fifo_free;
   logic              req_valid;
   logic              req_ready;
   logic [31:0]       req_address;
   logic [LEN_W-1:0]  req_length;
   logic              req_su;
   logic              rsp_valid;
   logic [LEN_W-1:0]  rsp_length;
   logic              rsp_keep;
   logic              limit_signal_do;

   always #5 clk = ~clk;

   prefetch_engine #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W),
      .FREE_W  (FREE_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .pr_reset        (pr_reset),
      .prefetch_cpl    (prefetch_cpl),
      .prefetch_eip    (prefetch_eip),
      .cs_cache        (cs_cache),
      .fifo_free       (fifo_free),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_address     (req_address),
      .req_length      (req_length),
      .req_su          (req_su),
      .rsp_valid       (rsp_valid),
      .rsp_length      (rsp_length),
      .rsp_keep        (rsp_keep),
      .limit_signal_do (limit_signal_do)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [31:0] m_linear;
   longint      m_limit;
   logic [1:0]  m_cpl;

   int pulse_cnt  = 0;
   int rv_cnt     = 0;
   int pulse_base = 0;

   // count limit pulses and offered-request cycles mid-cycle
   always @(negedge clk) begin
      if (limit_signal_do) pulse_cnt++;
      if (req_valid)       rv_cnt++;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time budget exhausted");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] make_desc(input logic [31:0] base, input logic [19:0] lim,
                                             input logic g);
      logic [63:0] d;
      d        = 64'd0;
      d[63:56] = base[31:24];
      d[39:16] = base[23:0];
      d[15:0]  = lim[15:0];
      d[51:48] = lim[19:16];
      d[55]    = g;
      d[47]    = 1'b1;
      return d;
   endfunction

   // bytes the next request should ask for, from the model state
   function automatic longint exp_len();
      longint e;
      longint page;
      e    = MAX_LEN;
      page = 4096 - longint'(m_linear % 4096);
      if (m_limit < e)             e = m_limit;
      if (longint'(fifo_free) < e) e = longint'(fifo_free);
      if (page < e)                e = page;
      return e;
   endfunction

   task automatic flush(input logic [31:0] base, input logic [19:0] lim, input logic g,
                        input logic [31:0] eip, input logic [1:0] cpl);
      longint cs_lim;
      cs_cache     = make_desc(base, lim, g);
      prefetch_eip = eip;
      prefetch_cpl = cpl;
      pr_reset     = 1'b1;
      step();
      pr_reset     = 1'b0;
      cs_lim   = g ? (longint'(lim) * 4096 + 4095) : longint'(lim);
      m_limit  = (cs_lim >= longint'(eip)) ? cs_lim - longint'(eip) + 1 : 0;
      m_linear = base + eip;
      m_cpl    = cpl;
      pulse_base = pulse_cnt;
   endtask

   task automatic wait_req(output int waited, output bit ok);
      waited = 0;
      ok     = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (req_valid) begin
            ok = 1'b1;
            break;
         end
         step();
         waited++;
      end
      check_eq("req_seen", 64'(ok), 64'd1);
   endtask

   // one request/response; rsp_len < 0 echoes the expected length;
   // hold_mode: 0 static fifo_free, 1 ramp 3->20, 2 random fifo_free while held
   task automatic run_txn(input int rsp_len, input int ready_dly, input int rsp_dly,
                          input int hold_mode, output int waited);
      bit     ok;
      longint e;
      longint d;
      int     rl;
      wait_req(waited, ok);
      if (!ok) return;
      e = exp_len();
      check_eq("req_addr", 64'(req_address), 64'(m_linear));
      check_eq("req_len",  64'(req_length),  64'(e));
      check_eq("req_su",   64'(req_su),      64'(m_cpl == 2'd3));
      for (int i = 0; i < ready_dly; i++) begin
         if (hold_mode == 1) fifo_free = FREE_W'(3 + (17 * (i + 1)) / ready_dly);
         if (hold_mode == 2) fifo_free = FREE_W'($urandom_range(0, 40));
         step();
         check_eq("hold_valid", 64'(req_valid),   64'd1);
         check_eq("hold_addr",  64'(req_address), 64'(m_linear));
         check_eq("hold_len",   64'(req_length),  64'(e));
      end
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      check_eq("accepted_valid", 64'(req_valid), 64'd0);
      repeat (rsp_dly) step();
      rl = (rsp_len < 0) ? int'(e) : rsp_len;
      rsp_valid  = 1'b1;
      rsp_length = LEN_W'(rl);
      #1;
      check_eq("rsp_keep", 64'(rsp_keep), 64'd1);
      step();
      rsp_valid = 1'b0;
      d = (longint'(rl) < e) ? longint'(rl) : e;
      m_linear = m_linear + 32'(d);
      m_limit  = m_limit - d;
   endtask

   // after exhaustion: one pulse, no further requests
   task automatic end_check(input string tag);
      int rvb;
      rvb = rv_cnt;
      repeat (6) step();
      check_eq({tag, "_noreq"}, 64'(rv_cnt - rvb), 64'd0);
      check_eq({tag, "_pulse"}, 64'(pulse_cnt - pulse_base), 64'd1);
   endtask

   initial begin
      int          w;
      bit          ok;
      logic [31:0] base;
      logic [31:0] eip;
      logic [19:0] lim;
      logic [11:0] off;

      rst = 1'b1; pr_reset = 1'b0; prefetch_cpl = 2'd3; prefetch_eip = 32'd0;
      cs_cache = 64'd0; fifo_free = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_length = '0;
      repeat (3) step();

      // reset state
      check_eq("rst_valid", 64'(req_valid),       64'd0);
      check_eq("rst_addr",  64'(req_address),     64'd0);
      check_eq("rst_len",   64'(req_length),      64'd0);
      check_eq("rst_su",    64'(req_su),          64'd1);
      check_eq("rst_keep",  64'(rsp_keep),        64'd0);
      check_eq("rst_limit", 64'(limit_signal_do), 64'd0);

      // startup fetch window: 16 bytes at FFFF_FFF0
      rst = 1'b0; fifo_free = 6'd32;
      m_linear = 32'hFFFF_FFF0; m_limit = 16; m_cpl = 2'd3; pulse_base = pulse_cnt;
      run_txn(-1, 1, 1, 0, w);
      end_check("startup");

      // long linear stream, base 0x1000, eip 0x10, limit 0xFFFF
      flush(32'h1000, 20'h0FFFF, 1'b0, 32'h10, 2'd0);
      run_txn(-1, 0, 0, 0, w);
      check_eq("flush_latency", 64'(w), 64'd1);
      for (int n = 0; n < 5000 && m_limit > 0; n++) begin
         run_txn(-1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0, w);
      end
      end_check("stream");

      // six bytes left before the limit
      flush(32'h0, 20'h0FFFF, 1'b0, 32'hFFFA, 2'd3);
      run_txn(-1, 0, 1, 0, w);
      end_check("tail6");

      // 4 GB segment: limit register becomes 2^32, never exhausts
      flush(32'h0, 20'hFFFFF, 1'b1, 32'h0, 2'd0);
      for (int n = 0; n < 3; n++) run_txn(-1, 0, 0, 0, w);
      repeat (2) step();
      check_eq("big_seg_pulse", 64'(pulse_cnt - pulse_base), 64'd0);

      // page split at 0xFF8 then continue at 0x1000
      flush(32'h0, 20'h0FFFF, 1'b0, 32'hFF8, 2'd0);
      run_txn(-1, 0, 0, 0, w);
      run_txn(-1, 0, 0, 0, w);
      check_eq("page_next_addr", 64'(m_linear), 64'h1010);

      // flush while waiting: stale response discarded, restart at new address
      flush(32'h2000, 20'h0FFFF, 1'b0, 32'h0, 2'd0);
      wait_req(w, ok);
      check_eq("wf_addr", 64'(req_address), 64'(m_linear));
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      flush(32'h5000, 20'h0FFFF, 1'b0, 32'h20, 2'd0);
      check_eq("wf_valid", 64'(req_valid), 64'd0);
      step();
      step();
      rsp_valid = 1'b1; rsp_length = 7'd16;
      #1;
      check_eq("wf_keep", 64'(rsp_keep), 64'd0);
      step();
      rsp_valid = 1'b0;
      run_txn(-1, 0, 0, 0, w);

      // narrow FIFO: length frozen at 3, over-long response advances by 3
      fifo_free = 6'd3;
      flush(32'h0, 20'h0FFFF, 1'b0, 32'h100, 2'd0);
      run_txn(10, 4, 1, 1, w);
      run_txn(-1, 0, 0, 0, w);
      check_eq("narrow_next", 64'(m_linear), 64'h113);

      // randomized sessions
      for (int s = 0; s < 30; s++) begin
         lim  = 20'($urandom_range(0, 16'hFFFF));
         eip  = ($urandom_range(0, 3) == 0) ? 32'(lim) + 32'($urandom_range(1, 8))
                                            : 32'(lim) - 32'($urandom_range(0, 90));
         if (eip > 32'(lim) + 32'd8) eip = 32'd0;
         base = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            off        = 12'hFE0 - eip[11:0] + 12'($urandom_range(0, 31));
            base[11:0] = off;
         end
         fifo_free = FREE_W'($urandom_range(1, 40));
         flush(base, lim, 1'b0, eip, 2'($urandom_range(0, 3)));
         for (int n = 0; n < 12 && m_limit > 0; n++) begin
            run_txn(int'($urandom_range(0, 19)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 2, w);
            fifo_free = FREE_W'($urandom_range(1, 40));
         end
         if (m_limit == 0) end_check("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
